// File: rtl/mips16_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips16_pkg
//  Description : Shared definitions for the 16-bit MIPS pipeline: opcode
//                encoding, multiplier FSM state encoding and the default
//                datapath width.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips16_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOT  = 4'd5,
        OP_SLL  = 4'd6,
        OP_SRL  = 4'd7,
        OP_SRA  = 4'd8,
        OP_SLT  = 4'd9,
        OP_MUL  = 4'd10,
        OP_LW   = 4'd11,
        OP_SW   = 4'd12,
        OP_LI   = 4'd13,
        OP_NOP  = 4'd14,
        OP_RSVD = 4'd15
    } opcode_e;

    typedef enum logic [0:0] {
        MUL_IDLE = 1'b0,
        MUL_BUSY = 1'b1
    } mul_state_e;

endpackage : mips16_pkg
`default_nettype wire

// File: rtl/seq_multiplier_16.sv
`default_nettype none
// ============================================================================
//  Module      : seq_multiplier_16
//  Description : Iterative shift-add multiplier producing the low WIDTH bits
//                of the unsigned product, one multiplier bit per cycle.
//  Ports       : clk, reset  - clock, synchronous active-high reset
//                start       - load a/b and begin (honoured only when idle)
//                a, b        - multiplicand, multiplier
//                busy        - an operation is in progress
//                last        - final iteration; product is valid this cycle
//                product     - final accumulation (meaningful when last=1)
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_multiplier_16
    import mips16_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int MUL_CYCLES = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             last,
    output logic [WIDTH-1:0] product
);

    localparam int                CNT_W  = $clog2(MUL_CYCLES);
    localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(MUL_CYCLES - 1);

    mul_state_e        r_state, w_state_n;
    logic [CNT_W-1:0]  r_cnt,   w_cnt_n;
    logic [WIDTH-1:0]  r_acc,   w_acc_n;
    logic [WIDTH-1:0]  r_mcand, w_mcand_n;
    logic [WIDTH-1:0]  r_mplier, w_mplier_n;
    logic [WIDTH-1:0]  w_sum;

    // Accumulation for the current iteration; on the last iteration this is
    // the finished product, handed out combinationally so the execute stage
    // can register it on the same edge the FSM returns to idle.
    assign w_sum   = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign busy    = (r_state == MUL_BUSY);
    assign last    = busy && (r_cnt == C_LAST);
    assign product = w_sum;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= MUL_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else begin
            r_state  <= w_state_n;
            r_cnt    <= w_cnt_n;
            r_acc    <= w_acc_n;
            r_mcand  <= w_mcand_n;
            r_mplier <= w_mplier_n;
        end
    end

    always_comb begin
        w_state_n  = r_state;
        w_cnt_n    = r_cnt;
        w_acc_n    = r_acc;
        w_mcand_n  = r_mcand;
        w_mplier_n = r_mplier;
        case (r_state)
            MUL_IDLE: begin
                if (start) begin
                    w_mcand_n  = a;
                    w_mplier_n = b;
                    w_acc_n    = '0;
                    w_cnt_n    = '0;
                    w_state_n  = MUL_BUSY;
                end
            end
            MUL_BUSY: begin
                w_acc_n    = w_sum;
                w_mcand_n  = r_mcand << 1;
                w_mplier_n = r_mplier >> 1;
                w_cnt_n    = r_cnt + 1'b1;
                if (last) begin
                    w_cnt_n   = '0;
                    w_state_n = MUL_IDLE;
                end
            end
            default: w_state_n = MUL_IDLE;
        endcase
    end

endmodule : seq_multiplier_16
`default_nettype wire

// File: rtl/execute_stage_block.sv
`default_nettype none
// ============================================================================
//  Module      : execute_stage_block
//  Description : Execute stage of the 16-bit MIPS pipeline. Selects operand B,
//                computes the ALU result (MUL via an iterative multiplier that
//                stalls decode) and registers result plus memory controls into
//                the EX/DM pipeline register.
//  Ports       : clk, reset            - clock, synchronous active-high reset
//                valid_dec, op_dec     - instruction valid and opcode
//                a_dec, b_dec, imm_dec - operands; imm_sel_dec picks imm as B
//                store_data_dec        - data to store
//                mem_rw/en/mux_sel_dec - memory controls from decode
//                ans_ex, DM_data       - registered result/address, store data
//                mem_rw_ex, mem_en_ex,
//                mem_mux_sel_dm        - registered memory controls
//                ovf_ex                - registered signed overflow (ADD/SUB/LW/SW)
//                stall_ex              - combinational; decode holds inputs
//  Revision    : 1.0 - initial release
// ============================================================================
module execute_stage_block
    import mips16_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int MUL_CYCLES = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_dec,
    input  logic [3:0]       op_dec,
    input  logic [WIDTH-1:0] a_dec,
    input  logic [WIDTH-1:0] b_dec,
    input  logic [WIDTH-1:0] imm_dec,
    input  logic             imm_sel_dec,
    input  logic [WIDTH-1:0] store_data_dec,
    input  logic             mem_rw_dec,
    input  logic             mem_en_dec,
    input  logic             mem_mux_sel_dec,
    output logic [WIDTH-1:0] ans_ex,
    output logic [WIDTH-1:0] DM_data,
    output logic             mem_rw_ex,
    output logic             mem_en_ex,
    output logic             mem_mux_sel_dm,
    output logic             ovf_ex,
    output logic             stall_ex
);

    logic [WIDTH-1:0] w_opb;
    logic [WIDTH-1:0] w_add, w_sub, w_alu;
    logic             w_ovf_add, w_ovf_sub, w_ovf;
    logic [3:0]       w_shamt;
    logic             w_is_mul, w_mul_start, w_mul_busy, w_mul_last;
    logic             w_bubble;
    logic [WIDTH-1:0] w_mul_product;

    assign w_opb   = imm_sel_dec ? imm_dec : b_dec;
    assign w_shamt = w_opb[3:0];
    assign w_add   = a_dec + w_opb;
    assign w_sub   = a_dec - w_opb;

    // Signed overflow: operands agree in sign (add) or differ (sub) and the
    // result sign differs from operand A.
    assign w_ovf_add = (a_dec[WIDTH-1] == w_opb[WIDTH-1]) && (w_add[WIDTH-1] != a_dec[WIDTH-1]);
    assign w_ovf_sub = (a_dec[WIDTH-1] != w_opb[WIDTH-1]) && (w_sub[WIDTH-1] != a_dec[WIDTH-1]);

    assign w_is_mul    = valid_dec && (op_dec == OP_MUL);
    // A MUL still presented by decode while busy must not relaunch the FSM.
    assign w_mul_start = w_is_mul && !w_mul_busy;

    // Decode is released in the final iteration so the next instruction
    // arrives the cycle after the product is registered.
    assign stall_ex = !reset && (w_mul_busy ? !w_mul_last : w_is_mul);

    assign w_bubble = !valid_dec || (op_dec == OP_NOP) || (op_dec == OP_RSVD) || stall_ex;

    seq_multiplier_16 #(
        .WIDTH      (WIDTH),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (w_mul_start),
        .a       (a_dec),
        .b       (w_opb),
        .busy    (w_mul_busy),
        .last    (w_mul_last),
        .product (w_mul_product)
    );

    always_comb begin
        w_alu = '0;
        w_ovf = 1'b0;
        case (op_dec)
            OP_ADD, OP_LW, OP_SW: begin
                w_alu = w_add;
                w_ovf = w_ovf_add;
            end
            OP_SUB: begin
                w_alu = w_sub;
                w_ovf = w_ovf_sub;
            end
            OP_AND:  w_alu = a_dec & w_opb;
            OP_OR:   w_alu = a_dec | w_opb;
            OP_XOR:  w_alu = a_dec ^ w_opb;
            OP_NOT:  w_alu = ~a_dec;
            OP_SLL:  w_alu = a_dec << w_shamt;
            OP_SRL:  w_alu = a_dec >> w_shamt;
            OP_SRA:  w_alu = $unsigned($signed(a_dec) >>> w_shamt);
            OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(a_dec) < $signed(w_opb))};
            OP_LI:   w_alu = w_opb;
            default: w_alu = '0;
        endcase
    end

    // EX/DM pipeline register
    always_ff @(posedge clk) begin
        if (reset) begin
            ans_ex         <= '0;
            DM_data        <= '0;
            mem_rw_ex      <= 1'b0;
            mem_en_ex      <= 1'b0;
            mem_mux_sel_dm <= 1'b0;
            ovf_ex         <= 1'b0;
        end else if (w_mul_last) begin
            // Controls come from the MUL still held by decode.
            ans_ex         <= w_mul_product;
            DM_data        <= store_data_dec;
            mem_rw_ex      <= mem_rw_dec;
            mem_en_ex      <= mem_en_dec;
            mem_mux_sel_dm <= mem_mux_sel_dec;
            ovf_ex         <= 1'b0;
        end else if (w_bubble) begin
            ans_ex         <= '0;
            DM_data        <= '0;
            mem_rw_ex      <= 1'b0;
            mem_en_ex      <= 1'b0;
            mem_mux_sel_dm <= 1'b0;
            ovf_ex         <= 1'b0;
        end else begin
            ans_ex         <= w_alu;
            DM_data        <= store_data_dec;
            mem_rw_ex      <= mem_rw_dec;
            mem_en_ex      <= mem_en_dec;
            mem_mux_sel_dm <= mem_mux_sel_dec;
            ovf_ex         <= w_ovf;
        end
    end

endmodule : execute_stage_block
`default_nettype wire

// File: tb/tb_execute_stage_block.sv
`default_nettype none
// ============================================================================
//  Module      : tb_execute_stage_block
//  Description : Self-checking bench for execute_stage_block: directed vector
//                table, randomized ALU ops against a reference model, and
//                hand-written multiply / reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_execute_stage_block;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_dec;
    logic [3:0]  op_dec;
    logic [15:0] a_dec, b_dec, imm_dec, store_data_dec;
    logic        imm_sel_dec, mem_rw_dec, mem_en_dec, mem_mux_sel_dec;
    logic [15:0] ans_ex, DM_data;
    logic        mem_rw_ex, mem_en_ex, mem_mux_sel_dm, ovf_ex, stall_ex;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    execute_stage_block #(.WIDTH(16), .MUL_CYCLES(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .valid_dec       (valid_dec),
        .op_dec          (op_dec),
        .a_dec           (a_dec),
        .b_dec           (b_dec),
        .imm_dec         (imm_dec),
        .imm_sel_dec     (imm_sel_dec),
        .store_data_dec  (store_data_dec),
        .mem_rw_dec      (mem_rw_dec),
        .mem_en_dec      (mem_en_dec),
        .mem_mux_sel_dec (mem_mux_sel_dec),
        .ans_ex          (ans_ex),
        .DM_data         (DM_data),
        .mem_rw_ex       (mem_rw_ex),
        .mem_en_ex       (mem_en_ex),
        .mem_mux_sel_dm  (mem_mux_sel_dm),
        .ovf_ex          (ovf_ex),
        .stall_ex        (stall_ex)
    );

    // {ans, DM_data, rw, en, mux, ovf}
    logic [35:0] outs;
    assign outs = {ans_ex, DM_data, mem_rw_ex, mem_en_ex, mem_mux_sel_dm, ovf_ex};

    typedef struct {
        logic        valid;
        logic [3:0]  op;
        logic [15:0] a, b, imm;
        logic        sel;
        logic [15:0] sd;
        logic        rw, en, mux;
        logic [35:0] exp;
    } vec_t;

    function automatic logic [35:0] mk_exp(input logic [15:0] ans, dm,
                                           input logic rw, en, mux, ovf);
        return {ans, dm, rw, en, mux, ovf};
    endfunction

    function automatic vec_t mkv(input logic valid, input logic [3:0] op,
                                 input logic [15:0] a, b, imm, input logic sel,
                                 input logic [15:0] sd, input logic rw, en, mux,
                                 input logic [35:0] exp);
        vec_t v;
        v.valid = valid; v.op = op; v.a = a; v.b = b; v.imm = imm; v.sel = sel;
        v.sd = sd; v.rw = rw; v.en = en; v.mux = mux; v.exp = exp;
        return v;
    endfunction

    // Reference model: arithmetic on plain integers, straight from the ISA rules.
    function automatic logic [35:0] ref_model(input vec_t v);
        logic [15:0] opb, ans;
        logic        ovf;
        int          sa, sb, s;
        logic [31:0] wide;
        int          sh;
        opb = v.sel ? v.imm : v.b;
        sa  = int'($signed(v.a));
        sb  = int'($signed(opb));
        sh  = int'(opb[3:0]);
        ans = 16'h0;
        ovf = 1'b0;
        if (!v.valid || v.op >= 4'd14) return 36'h0;
        case (v.op)
            4'd0, 4'd11, 4'd12: begin s = sa + sb; ans = s[15:0]; ovf = (s > 32767) || (s < -32768); end
            4'd1:  begin s = sa - sb; ans = s[15:0]; ovf = (s > 32767) || (s < -32768); end
            4'd2:  ans = v.a & opb;
            4'd3:  ans = v.a | opb;
            4'd4:  ans = v.a ^ opb;
            4'd5:  ans = ~v.a;
            4'd6:  begin wide = {16'h0, v.a} << sh; ans = wide[15:0]; end
            4'd7:  begin wide = {16'h0, v.a} >> sh; ans = wide[15:0]; end
            4'd8:  begin s = sa >>> sh; ans = s[15:0]; end
            4'd9:  ans = (sa < sb) ? 16'd1 : 16'd0;
            4'd10: begin wide = {16'h0, v.a} * {16'h0, opb}; ans = wide[15:0]; end
            default: ans = opb;
        endcase
        return {ans, v.sd, v.rw, v.en, v.mux, ovf};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        valid_dec       = v.valid;
        op_dec          = v.op;
        a_dec           = v.a;
        b_dec           = v.b;
        imm_dec         = v.imm;
        imm_sel_dec     = v.sel;
        store_data_dec  = v.sd;
        mem_rw_dec      = v.rw;
        mem_en_dec      = v.en;
        mem_mux_sel_dec = v.mux;
    endtask

    // Issues a MUL, measures stall length, watches for bubbles, checks result.
    task automatic run_mul(input logic [15:0] a, b, input string tag);
        vec_t v;
        int   n;
        logic bub_ok;
        v = mkv(1'b1, 4'd10, a, b, 16'h0, 1'b0, 16'h5A5A, 1'b0, 1'b1, 1'b1, 36'h0);
        v.exp = ref_model(v);
        drive(v);
        n = 0;
        bub_ok = 1'b1;
        #1;
        while (stall_ex && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (outs !== 36'h0) bub_ok = 1'b0;
        end
        check({tag, "_stall_len"}, n, 16);
        check({tag, "_bubbles"}, bub_ok, 1);
        @(posedge clk); #1;
        check({tag, "_result"}, outs, v.exp);
    endtask

    vec_t tbl[13];
    vec_t idle_v;

    initial begin
        idle_v = mkv(1'b0, 4'd14, 16'h0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 36'h0);

        tbl[0]  = mkv(1, 4'd0,  16'h7FFF, 16'h0001, 16'h0000, 0, 16'h1111, 0, 0, 0, mk_exp(16'h8000, 16'h1111, 0, 0, 0, 1));
        tbl[1]  = mkv(1, 4'd1,  16'h0005, 16'h0007, 16'h0000, 0, 16'h2222, 0, 0, 0, mk_exp(16'hFFFE, 16'h2222, 0, 0, 0, 0));
        tbl[2]  = mkv(1, 4'd12, 16'h0010, 16'h0000, 16'hFFFC, 1, 16'hBEEF, 1, 1, 0, mk_exp(16'h000C, 16'hBEEF, 1, 1, 0, 0));
        tbl[3]  = mkv(1, 4'd8,  16'h8000, 16'h0004, 16'h0000, 0, 16'h0000, 0, 0, 0, mk_exp(16'hF800, 16'h0000, 0, 0, 0, 0));
        tbl[4]  = mkv(1, 4'd9,  16'hFFFF, 16'h0001, 16'h0000, 0, 16'h0000, 0, 0, 0, mk_exp(16'h0001, 16'h0000, 0, 0, 0, 0));
        tbl[5]  = mkv(1, 4'd7,  16'h8000, 16'h000F, 16'h0000, 0, 16'h0000, 0, 0, 0, mk_exp(16'h0001, 16'h0000, 0, 0, 0, 0));
        tbl[6]  = mkv(1, 4'd14, 16'h1234, 16'h0001, 16'h0000, 0, 16'hAAAA, 1, 1, 1, 36'h0);
        tbl[7]  = mkv(0, 4'd0,  16'h1234, 16'h0001, 16'h0000, 0, 16'hAAAA, 1, 1, 1, 36'h0);
        tbl[8]  = mkv(1, 4'd15, 16'h1234, 16'h0001, 16'h0000, 0, 16'hAAAA, 1, 1, 1, 36'h0);
        tbl[9]  = mkv(1, 4'd13, 16'h0000, 16'h9999, 16'h1234, 1, 16'h0000, 0, 0, 0, mk_exp(16'h1234, 16'h0000, 0, 0, 0, 0));
        tbl[10] = mkv(1, 4'd5,  16'h00FF, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0, 0, mk_exp(16'hFF00, 16'h0000, 0, 0, 0, 0));
        tbl[11] = mkv(1, 4'd1,  16'h8000, 16'h0001, 16'h0000, 0, 16'h0000, 0, 0, 0, mk_exp(16'h7FFF, 16'h0000, 0, 0, 0, 1));
        tbl[12] = mkv(1, 4'd11, 16'hFFF0, 16'h0000, 16'h0020, 1, 16'h0000, 0, 1, 1, mk_exp(16'h0010, 16'h0000, 0, 1, 1, 0));

        // Power-on reset
        reset = 1'b1;
        drive(idle_v);
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", outs, 36'h0);
        check("reset_stall", stall_ex, 0);
        reset = 1'b0;

        // Directed vector table
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i]);
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), outs, tbl[i].exp);
        end

        // Randomized non-MUL traffic
        for (int i = 0; i < 300; i++) begin
            vec_t v;
            int   op;
            op = int'($urandom_range(0, 14));
            if (op >= 10) op++;
            v = mkv(($urandom_range(0, 9) != 0), 4'(op), 16'($urandom), 16'($urandom),
                    16'($urandom), 1'($urandom), 16'($urandom), 1'($urandom),
                    1'($urandom), 1'($urandom), 36'h0);
            v.exp = ref_model(v);
            drive(v);
            #1;
            if (stall_ex !== 1'b0) check($sformatf("rand%0d_stall", i), stall_ex, 0);
            @(posedge clk); #1;
            check($sformatf("rand%0d", i), outs, v.exp);
        end

        // Reset held for two cycles mid-stream, with a MUL presented
        drive(mkv(1, 4'd0, 16'h0001, 16'h0002, 16'h0, 0, 16'h0, 0, 0, 0, 36'h0));
        @(posedge clk); #1;
        reset = 1'b1;
        drive(mkv(1, 4'd10, 16'h0003, 16'h0004, 16'h0, 0, 16'h0, 0, 1, 0, 36'h0));
        #1;
        check("rst2_stall_a", stall_ex, 0);
        @(posedge clk); #1;
        check("rst2_out_a", outs, 36'h0);
        check("rst2_stall_b", stall_ex, 0);
        @(posedge clk); #1;
        check("rst2_out_b", outs, 36'h0);
        reset = 1'b0;
        drive(mkv(1, 4'd0, 16'h0003, 16'h0004, 16'h0, 0, 16'h0, 0, 0, 0, 36'h0));
        @(posedge clk); #1;
        check("rst2_first_add", outs, mk_exp(16'h0007, 16'h0000, 0, 0, 0, 0));

        // Multiplies: directed, back-to-back, random
        run_mul(16'h0123, 16'h0045, "mul_a");
        run_mul(16'hFFFF, 16'hFFFF, "mul_b2b");
        for (int i = 0; i < 4; i++) run_mul(16'($urandom), 16'($urandom), $sformatf("mul_r%0d", i));
        drive(idle_v);
        @(posedge clk); #1;
        check("post_mul_idle", outs, 36'h0);

        // Reset in cycle 8 of a MUL aborts it
        begin
            logic quiet;
            drive(mkv(1, 4'd10, 16'h0101, 16'h0003, 16'h0, 0, 16'h7777, 0, 1, 1, 36'h0));
            repeat (8) @(posedge clk);
            #1;
            reset = 1'b1;
            #1;
            check("rstmul_stall", stall_ex, 0);
            @(posedge clk); #1;
            reset = 1'b0;
            drive(idle_v);
            quiet = 1'b1;
            for (int i = 0; i < 24; i++) begin
                @(posedge clk); #1;
                if (outs !== 36'h0 || stall_ex !== 1'b0) quiet = 1'b0;
            end
            check("rstmul_no_result", quiet, 1);
            drive(mkv(1, 4'd0, 16'h0010, 16'h0020, 16'h0, 0, 16'h0, 0, 0, 0, 36'h0));
            @(posedge clk); #1;
            check("rstmul_next_add", outs, mk_exp(16'h0030, 16'h0000, 0, 0, 0, 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_execute_stage_block
`default_nettype wire
